disp_char_sequencer: RTL

Sits between the Morse decoder and seven_seg_disp and sequences the 8-digit display. It accepts decoded ASCII characters via a valid/ready handshake and buffers them in a small FIFO. It drives the display's character bus, letter_done (advance) and reset (clear) so that each character lands in the next free digit. When all 8 digits are full, it clears the line automatically before writing the next character.

---
 rtl/disp_char_sequencer_pkg.sv | 18 +
 rtl/disp_char_fifo.sv | 53 +++++
 rtl/disp_char_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/disp_char_sequencer_pkg.sv
// Shared types and default timing for the display character sequencer.
// The FSM state type is also exported on the top-level debug port.
package disp_char_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_ADV   = 2'd2,
        S_LOAD  = 2'd3
    } seq_state_e;

    localparam logic [7:0] ASCII_BLANK = 8'h20;

    localparam int ADV_W_DEF    = 4;
    localparam int HOLD_CYC_DEF = 16;
    localparam int CLR_W_DEF    = 4;

endpackage

// File: rtl/disp_char_fifo.sv
// Synchronous FIFO with full/empty flags and an occupancy count.
// DEPTH must be a power of two so that the pointers wrap by natural overflow.
module disp_char_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/disp_char_sequencer.sv
// Buffers decoded characters and paces them onto an 8-digit seven-segment line
// using advance/clear pulses; auto-clears the line once every digit is written.
module disp_char_sequencer
    import disp_char_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_DIGITS = 8,
    parameter int ADV_W      = ADV_W_DEF,
    parameter int HOLD_CYC   = HOLD_CYC_DEF,
    parameter int CLR_W      = CLR_W_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] in_char,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       clear_req,
    output logic [7:0] disp_char,
    output logic       disp_advance,
    output logic       disp_clear,
    output logic [3:0] slots_used,
    output logic       busy,
    output logic       overflow,
    output seq_state_e state
);

    localparam int CNT_W = $clog2(ADV_W + HOLD_CYC + CLR_W + 1);

    seq_state_e                  state_nxt;
    seq_state_e                  dispatch_state;
    logic [CNT_W-1:0]            cnt;
    logic [7:0]                  char_q;
    logic                        clr_pend;
    logic                        want_clear;
    logic                        dispatch_pop;
    logic                        pop;
    logic [7:0]                  fifo_rdata;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // Handshake: a character transfers on any cycle where in_valid && in_ready;
    // in_ready comes from the registered FIFO count, never from in_valid.
    disp_char_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (in_valid),
        .pop   (pop),
        .wdata (in_char),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign in_ready = !fifo_full;
    assign busy     = (state != S_IDLE) || (fifo_count != '0);

    // LOAD exit dispatches directly, so a queued character costs ADV_W+HOLD_CYC cycles.
    always_comb begin
        want_clear     = clear_req || clr_pend ||
                         (!fifo_empty && slots_used == 4'(NUM_DIGITS));
        dispatch_state = S_IDLE;
        dispatch_pop   = 1'b0;
        if (want_clear) begin
            dispatch_state = S_CLEAR;
        end else if (!fifo_empty) begin
            dispatch_state = S_ADV;
            dispatch_pop   = 1'b1;
        end

        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = dispatch_state;
                pop       = dispatch_pop;
            end
            S_CLEAR: if (cnt == CNT_W'(CLR_W - 1)) state_nxt = S_IDLE;
            S_ADV:   if (cnt == CNT_W'(ADV_W - 1)) state_nxt = S_LOAD;
            S_LOAD: begin
                if (cnt == CNT_W'(HOLD_CYC - 1)) begin
                    state_nxt = dispatch_state;
                    pop       = dispatch_pop;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            char_q       <= ASCII_BLANK;
            disp_char    <= ASCII_BLANK;
            disp_advance <= 1'b0;
            disp_clear   <= 1'b0;
            slots_used   <= '0;
            clr_pend     <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state        <= state_nxt;
            disp_advance <= (state_nxt == S_ADV);
            disp_clear   <= (state_nxt == S_CLEAR);

            if (state_nxt != state) cnt <= '0;
            else if (state != S_IDLE) cnt <= cnt + CNT_W'(1);

            if (pop) char_q <= fifo_rdata;

            if (state == S_ADV && state_nxt == S_LOAD) begin
                disp_char <= char_q;
                if (slots_used < 4'(NUM_DIGITS)) slots_used <= slots_used + 4'd1;
            end
            if (state != S_CLEAR && state_nxt == S_CLEAR) disp_char <= ASCII_BLANK;

            if (clear_req && state != S_IDLE) clr_pend <= 1'b1;
            if (state == S_CLEAR && state_nxt != S_CLEAR) begin
                slots_used <= '0;
                clr_pend   <= 1'b0;
                overflow   <= 1'b0;
            end
            // A rejected push in the same cycle as a clear exit still counts.
            if (in_valid && fifo_full) overflow <= 1'b1;
        end
    end

endmodule
